// File: rtl/sram_arbiter_pkg.sv
// Shared state encoding and requester IDs for the two-port SRAM arbiter.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } arbState_t;

  localparam logic REQ_JTAG = 1'b0;
  localparam logic REQ_CORE = 1'b1;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates JTAG and core accesses onto one asynchronous SRAM port using a
// SETUP/STROBE/HOLD cycle; every SRAM pin and ack comes straight from a flop.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int STROBE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        jtag_req,
  input  logic        jtag_wr,
  input  logic [15:0] jtag_addr,
  input  logic [15:0] jtag_wdata,
  output logic        jtag_ack,
  output logic [15:0] jtag_rdata,
  input  logic        core_req,
  input  logic        core_wr,
  input  logic [15:0] core_addr,
  input  logic [15:0] core_wdata,
  output logic        core_ack,
  output logic [15:0] core_rdata,
  input  logic        pause,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        sram_data_oe,
  input  logic [15:0] sram_rdata,
  output logic        sram_wr,
  output logic        sram_en,
  output logic        busy
);

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES);

  arbState_t   stateReg, stateNext;
  logic [3:0]  cntReg, cntNext;
  logic        lastGrantReg, ownerReg;
  logic        wrLatchReg;
  logic [15:0] addrLatchReg, wdataLatchReg;
  logic        grant, grantId;
  logic        wrNext;
  logic [15:0] addrNext, wdataNext;
  logic        captureRead;

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    grant     = 1'b0;
    grantId   = REQ_JTAG;
    case (stateReg)
      IDLE: begin
        // A paused core is never eligible, so a tie always means pause = 0.
        if (jtag_req && core_req && !pause) begin
          grant   = 1'b1;
          grantId = (lastGrantReg == REQ_JTAG) ? REQ_CORE : REQ_JTAG;
        end else if (jtag_req) begin
          grant   = 1'b1;
          grantId = REQ_JTAG;
        end else if (core_req && !pause) begin
          grant   = 1'b1;
          grantId = REQ_CORE;
        end
        if (grant) stateNext = SETUP;
      end
      SETUP: begin
        stateNext = STROBE;
        cntNext   = STROBE_LOAD;
      end
      STROBE: begin
        if (cntReg <= 4'd1) stateNext = HOLD;
        else                cntNext   = cntReg - 4'd1;
      end
      HOLD:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    wrNext    = wrLatchReg;
    addrNext  = addrLatchReg;
    wdataNext = wdataLatchReg;
    if (grant) begin
      wrNext    = (grantId == REQ_JTAG) ? jtag_wr    : core_wr;
      addrNext  = (grantId == REQ_JTAG) ? jtag_addr  : core_addr;
      wdataNext = (grantId == REQ_JTAG) ? jtag_wdata : core_wdata;
    end
    captureRead = (stateReg == STROBE) && (stateNext == HOLD) && !wrLatchReg;
  end

  // Pins are registered from the next state so they line up with the state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stateReg      <= IDLE;
      cntReg        <= 4'd0;
      lastGrantReg  <= REQ_CORE;
      ownerReg      <= REQ_JTAG;
      wrLatchReg    <= 1'b0;
      addrLatchReg  <= 16'd0;
      wdataLatchReg <= 16'd0;
      sram_en       <= 1'b0;
      sram_wr       <= 1'b0;
      sram_data_oe  <= 1'b0;
      sram_addr     <= 16'd0;
      sram_wdata    <= 16'd0;
      jtag_ack      <= 1'b0;
      core_ack      <= 1'b0;
      jtag_rdata    <= 16'd0;
      core_rdata    <= 16'd0;
    end else begin
      stateReg      <= stateNext;
      cntReg        <= cntNext;
      wrLatchReg    <= wrNext;
      addrLatchReg  <= addrNext;
      wdataLatchReg <= wdataNext;
      if (grant) begin
        ownerReg     <= grantId;
        lastGrantReg <= grantId;
      end
      sram_en      <= (stateNext != IDLE);
      sram_wr      <= (stateNext == STROBE) && wrNext;
      sram_data_oe <= (stateNext != IDLE) && wrNext;
      sram_addr    <= addrNext;
      sram_wdata   <= wdataNext;
      jtag_ack     <= (stateNext == HOLD) && (ownerReg == REQ_JTAG);
      core_ack     <= (stateNext == HOLD) && (ownerReg == REQ_CORE);
      if (captureRead && ownerReg == REQ_JTAG) jtag_rdata <= sram_rdata;
      if (captureRead && ownerReg == REQ_CORE) core_rdata <= sram_rdata;
    end
  end

  assign busy = (stateReg != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and randomized checks of sram_arbiter against a transaction-level
// model of arbitration, access latency and SRAM contents.
module tb_sram_arbiter;

  localparam int S  = 1;
  localparam int S3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, rstn3;
  logic        jtagReq, jtagWr, coreReq, coreWr, pause;
  logic [15:0] jtagAddr, jtagWdata, coreAddr, coreWdata;

  logic        jtagAck, coreAck, sramOe, sramWr, sramEn, busy;
  logic [15:0] jtagRdata, coreRdata, sramAddr, sramWdata, sramRdata;
  logic        jtagAck3, coreAck3, sramOe3, sramWr3, sramEn3, busy3;
  logic [15:0] jtagRdata3, coreRdata3, sramAddr3, sramWdata3;
  logic [15:0] sramRdata3 = 16'h0;

  // Behavioural SRAM behind the main instance (addresses alias on the low byte).
  logic [15:0] mem [0:255] = '{default: 16'h0};
  logic        forceRd = 1'b0;
  logic [15:0] forceVal = 16'h0;
  assign sramRdata = forceRd ? forceVal : mem[sramAddr[7:0]];
  always @(posedge clk) if (sramEn && sramWr) mem[sramAddr[7:0]] = sramWdata;

  sram_arbiter #(.STROBE_CYCLES(S)) dut (
    .clk(clk), .rstn(rstn),
    .jtag_req(jtagReq), .jtag_wr(jtagWr), .jtag_addr(jtagAddr), .jtag_wdata(jtagWdata),
    .jtag_ack(jtagAck), .jtag_rdata(jtagRdata),
    .core_req(coreReq), .core_wr(coreWr), .core_addr(coreAddr), .core_wdata(coreWdata),
    .core_ack(coreAck), .core_rdata(coreRdata),
    .pause(pause), .sram_addr(sramAddr), .sram_wdata(sramWdata), .sram_data_oe(sramOe),
    .sram_rdata(sramRdata), .sram_wr(sramWr), .sram_en(sramEn), .busy(busy)
  );

  sram_arbiter #(.STROBE_CYCLES(S3)) dut3 (
    .clk(clk), .rstn(rstn3),
    .jtag_req(jtagReq), .jtag_wr(jtagWr), .jtag_addr(jtagAddr), .jtag_wdata(jtagWdata),
    .jtag_ack(jtagAck3), .jtag_rdata(jtagRdata3),
    .core_req(coreReq), .core_wr(coreWr), .core_addr(coreAddr), .core_wdata(coreWdata),
    .core_ack(coreAck3), .core_rdata(coreRdata3),
    .pause(pause), .sram_addr(sramAddr3), .sram_wdata(sramWdata3), .sram_data_oe(sramOe3),
    .sram_rdata(sramRdata3), .sram_wr(sramWr3), .sram_en(sramEn3), .busy(busy3)
  );

  int nTests = 0;
  int nFail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    jtagReq = 1'b0; coreReq = 1'b0; pause = 1'b0;
    jtagWr = 1'b0; coreWr = 1'b0;
    jtagAddr = 16'h0; coreAddr = 16'h0; jtagWdata = 16'h0; coreWdata = 16'h0;
  endtask

  task automatic doReset();
    rstn = 1'b0;
    idleInputs();
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic waitAck(output int lat, output logic [1:0] who);
    lat = 0; who = 2'b00;
    while (who == 2'b00 && lat < 12) begin
      tick(); lat++;
      who = {jtagAck, coreAck};
    end
  endtask

  logic [15:0] shadow [0:255];
  logic [15:0] expJRd, expCRd, wAddr, wData;
  logic        lastModel, expWin, wWr, jOn, cOn, pOn;
  logic [1:0]  who;
  logic [1:0]  ackWho [4];
  int          ackCyc [4];
  int          lat, nAck, cnt, wrCyc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 16'h0;
    rstn3 = 1'b0;
    rstn  = 1'b0;
    idleInputs();
    tick(); tick();
    check("rst_ctrl", {jtagAck, coreAck, sramEn, sramWr, sramOe, busy}, 6'b0);
    check("rst_addr", sramAddr, 16'h0);
    check("rst_rdata", {jtagRdata, coreRdata}, 32'h0);
    rstn = 1'b1;
    tick();

    // JTAG write, one strobe cycle
    jtagReq = 1'b1; jtagWr = 1'b1; jtagAddr = 16'h00A5; jtagWdata = 16'h1234;
    tick();
    check("jw_c1_ctrl", {sramEn, sramWr, sramOe, jtagAck}, 4'b1010);
    check("jw_c1_addr", sramAddr, 16'h00A5);
    check("jw_c1_wdata", sramWdata, 16'h1234);
    tick();
    check("jw_c2_ctrl", {sramEn, sramWr, sramOe, jtagAck}, 4'b1110);
    tick();
    check("jw_c3_ctrl", {sramEn, sramWr, sramOe, jtagAck}, 4'b1011);
    jtagReq = 1'b0;
    tick();
    check("jw_c4_ctrl", {sramEn, sramWr, sramOe, jtagAck, busy}, 5'b0);
    check("jw_c4_addr_kept", sramAddr, 16'h00A5);
    check("jw_mem", mem[8'hA5], 16'h1234);
    shadow[8'hA5] = 16'h1234;

    // Core read with forced SRAM data
    doReset();
    check("rst2_addr", sramAddr, 16'h0);
    forceRd = 1'b1; forceVal = 16'hBEEF;
    coreReq = 1'b1; coreWr = 1'b0; coreAddr = 16'h0010;
    tick();
    check("cr_c1", {sramEn, sramWr, sramOe, coreAck}, 4'b1000);
    check("cr_c1_addr", sramAddr, 16'h0010);
    tick();
    check("cr_c2", {sramEn, sramWr, sramOe, coreAck}, 4'b1000);
    tick();
    check("cr_c3", {sramEn, sramWr, sramOe, coreAck}, 4'b1001);
    check("cr_rdata", coreRdata, 16'hBEEF);
    check("cr_jrd_untouched", jtagRdata, 16'h0);
    coreReq = 1'b0;
    tick();
    forceRd = 1'b0;
    check("cr_rdata_hold", coreRdata, 16'hBEEF);

    // Fair alternation with both requesting continuously
    doReset();
    jtagReq = 1'b1; coreReq = 1'b1; jtagAddr = 16'h0001; coreAddr = 16'h0002;
    nAck = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (jtagAck || coreAck) begin
        if (nAck < 4) begin ackCyc[nAck] = c; ackWho[nAck] = {jtagAck, coreAck}; end
        nAck++;
      end
    end
    check("tie_count", nAck, 4);
    for (int k = 0; k < 4; k++) begin
      check("tie_cycle", ackCyc[k], 3 + 4 * k);
      check("tie_who", ackWho[k], (k % 2 == 0) ? 2'b10 : 2'b01);
    end

    // Pause blocks the core until released
    doReset();
    jtagReq = 1'b1; coreReq = 1'b1; pause = 1'b1;
    nAck = 0; cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (jtagAck) nAck++;
      if (coreAck) cnt++;
    end
    check("pause_jacks", nAck, 4);
    check("pause_cacks", cnt, 0);
    pause = 1'b0;
    waitAck(lat, who);
    check("unpause_lat", lat, 3);
    check("unpause_who", who, 2'b01);
    idleInputs();
    tick();

    // Pause rising mid core access
    doReset();
    coreReq = 1'b1; coreAddr = 16'h0030;
    tick();
    pause = 1'b1;
    tick(); tick();
    check("midpause_ack", coreAck, 1'b1);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (coreAck || busy) cnt++;
    end
    check("midpause_no_regrant", cnt, 0);

    // Reset in the second strobe cycle of a 3-cycle strobe
    rstn = 1'b0;
    idleInputs();
    rstn3 = 1'b1;
    tick();
    jtagReq = 1'b1; jtagWr = 1'b1; jtagAddr = 16'h0055; jtagWdata = 16'hA5A5;
    tick();
    check("s3_c1", {sramEn3, sramWr3, sramOe3}, 3'b101);
    tick();
    check("s3_c2", {sramEn3, sramWr3, sramOe3}, 3'b111);
    tick();
    check("s3_c3", {sramEn3, sramWr3, sramOe3}, 3'b111);
    rstn3 = 1'b0;
    tick();
    check("s3_rst_ctrl", {sramEn3, sramWr3, sramOe3, jtagAck3, coreAck3, busy3}, 6'b0);
    check("s3_rst_addr", sramAddr3, 16'h0);
    check("s3_rst_wdata", sramWdata3, 16'h0);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (jtagAck3) cnt++;
    end
    check("s3_no_ack", cnt, 0);

    // Randomized transactions against the model
    doReset();
    lastModel = 1'b1;
    expJRd = 16'h0; expCRd = 16'h0;
    for (int r = 0; r < 80; r++) begin
      jOn = 1'($urandom_range(0, 1));
      cOn = 1'($urandom_range(0, 1));
      pOn = ($urandom_range(0, 3) == 0);
      jtagWr = 1'($urandom_range(0, 1)); coreWr = 1'($urandom_range(0, 1));
      jtagAddr = 16'($urandom); coreAddr = 16'($urandom);
      jtagWdata = 16'($urandom); coreWdata = 16'($urandom);
      jtagReq = jOn; coreReq = cOn; pause = pOn;
      if (!jOn && !(cOn && !pOn)) begin
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
          tick();
          if (jtagAck || coreAck || busy) cnt++;
        end
        check("rnd_noelig", cnt, 0);
        $display("[TB] txn %0d: no eligible request", r);
      end else begin
        if (jOn && cOn && !pOn) expWin = ~lastModel;
        else                    expWin = jOn ? 1'b0 : 1'b1;
        lastModel = expWin;
        wWr   = expWin ? coreWr : jtagWr;
        wAddr = expWin ? coreAddr : jtagAddr;
        wData = expWin ? coreWdata : jtagWdata;
        lat = 0; who = 2'b00; wrCyc = 0;
        while (who == 2'b00 && lat < 12) begin
          tick(); lat++;
          if (sramWr) wrCyc++;
          who = {jtagAck, coreAck};
        end
        if (wWr) shadow[wAddr[7:0]] = wData;
        else if (expWin) expCRd = shadow[wAddr[7:0]];
        else             expJRd = shadow[wAddr[7:0]];
        check("rnd_latency", lat, 2 + S);
        check("rnd_winner", who, expWin ? 2'b01 : 2'b10);
        check("rnd_addr", sramAddr, wAddr);
        check("rnd_strobes", wrCyc, wWr ? S : 0);
        check("rnd_jrdata", jtagRdata, expJRd);
        check("rnd_crdata", coreRdata, expCRd);
        $display("[TB] txn %0d: %s %s addr=%04h data=%04h", r,
                 expWin ? "core" : "jtag", wWr ? "wr" : "rd", wAddr,
                 wWr ? wData : (expWin ? expCRd : expJRd));
      end
      jtagReq = 1'b0; coreReq = 1'b0; pause = 1'b0;
      tick();
      check("rnd_idle", busy, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
